// File: rtl/multi_edge_pulse_gen.sv
// multi_edge_pulse_gen
// Multi-channel edge-to-pulse generator. Each channel synchronises an
// asynchronous level input and looks for rising, falling or both edges
// according to its edge_mode field. An accepted edge produces a pulse of
// max(pulse_len,1) cycles, followed by an optional hold-off lockout.
// Channels share only the clock, the reset, the length inputs and the
// post-reset arm counter. Everything else is replicated per channel.

module multi_edge_pulse_gen #(
   parameter int CHANNELS    = 3,
   parameter int CNT_W       = 6,
   parameter int SYNC_STAGES = 2,
   parameter int RETRIGGER   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   signal_in,
   input  logic [CHANNELS-1:0]   enable,
   input  logic [2*CHANNELS-1:0] edge_mode,
   input  logic [CNT_W-1:0]      pulse_len,
   input  logic [CNT_W-1:0]      holdoff_len,
   input  logic [CHANNELS-1:0]   clear,
   output logic [CHANNELS-1:0]   pulse_out,
   output logic [CHANNELS-1:0]   busy,
   output logic [CHANNELS-1:0]   event_sticky
);

   // Detection is suppressed for this many cycles after reset release, so
   // a level that was already high during reset never shows up as an edge.
   localparam int ARM_LAST = SYNC_STAGES + 1;
   localparam int ARM_W    = $clog2(ARM_LAST + 1);

   // A qualified edge in PULSE reloads the pulse counter only when set.
   localparam bit RETRIG_EN = (RETRIGGER != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_HOLDOFF
   } state_t;

   logic [ARM_W-1:0] r_arm_cnt;
   logic             w_armed;
   logic [CNT_W-1:0] w_pulse_ld;

   // Count up once after reset release and then stay saturated.
   // NOTE: clocked blocks use non-blocking assignments only, so every flop
   // sees the values from before the edge regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_arm_cnt <= '0;
      end else if (!w_armed) begin
         r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
   end

   assign w_armed = (r_arm_cnt == ARM_W'(ARM_LAST));

   // A programmed pulse length of zero behaves as a single-cycle pulse.
   assign w_pulse_ld = (pulse_len == '0) ? CNT_W'(1) : pulse_len;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_prev;
      state_t                 r_state;
      logic [CNT_W-1:0]       r_pcnt;
      logic [CNT_W-1:0]       r_hcnt;
      logic                   r_pulse;
      logic                   r_busy;
      logic                   r_sticky;
      logic                   w_s;
      logic                   w_rise;
      logic                   w_fall;
      logic                   w_qual;
      logic                   w_set;

      // Synchroniser chain plus the history flop used for edge detection.
      // Both keep running in every FSM state and while the channel is
      // disabled, so a level held through a pulse never fires later.
      // NOTE: the synchroniser is reset to 0 on purpose. Together with the
      // arm window this makes the first edge after reset well defined.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in[g]};
            r_prev <= r_sync[SYNC_STAGES-1];
         end
      end

      assign w_s    = r_sync[SYNC_STAGES-1];
      assign w_rise = w_s & ~r_prev;
      assign w_fall = ~w_s & r_prev;
      assign w_qual = w_armed & ((w_rise & edge_mode[2*g]) |
                                 (w_fall & edge_mode[2*g+1]));

      // An edge is accepted from IDLE, or from PULSE when retriggering is
      // built in. Edges seen in HOLDOFF are dropped.
      assign w_set = enable[g] & w_qual &
                     ((r_state == S_IDLE) | ((r_state == S_PULSE) & RETRIG_EN));

      // Per-channel IDLE/PULSE/HOLDOFF controller with registered outputs.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_sticky <= 1'b0;
         end else begin
            // Setting the sticky flag takes priority over a coincident clear.
            if (w_set) begin
               r_sticky <= 1'b1;
            end else if (clear[g]) begin
               r_sticky <= 1'b0;
            end

            if (!enable[g]) begin
               // Disabling aborts any pulse or hold-off immediately.
               r_state <= S_IDLE;
               r_pulse <= 1'b0;
               r_busy  <= 1'b0;
            end else begin
               unique case (r_state)
                  S_IDLE: begin
                     if (w_set) begin
                        // The lengths are latched here, so later changes
                        // to the inputs do not disturb this pulse.
                        r_state <= S_PULSE;
                        r_pcnt  <= w_pulse_ld;
                        r_hcnt  <= holdoff_len;
                        r_pulse <= 1'b1;
                        r_busy  <= 1'b1;
                     end
                  end

                  S_PULSE: begin
                     if (w_set) begin
                        // Retrigger: restart the count from the current
                        // length. The latched hold-off stays as it was.
                        r_pcnt <= w_pulse_ld;
                     end else if (r_pcnt == CNT_W'(1)) begin
                        r_pulse <= 1'b0;
                        if (r_hcnt != '0) begin
                           r_state <= S_HOLDOFF;
                        end else begin
                           r_state <= S_IDLE;
                           r_busy  <= 1'b0;
                        end
                     end else begin
                        r_pcnt <= r_pcnt - CNT_W'(1);
                     end
                  end

                  S_HOLDOFF: begin
                     if (r_hcnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_hcnt <= r_hcnt - CNT_W'(1);
                     end
                  end

                  default: begin
                     r_state <= S_IDLE;
                     r_pulse <= 1'b0;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign pulse_out[g]    = r_pulse;
      assign busy[g]         = r_busy;
      assign event_sticky[g] = r_sticky;
   end

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// tb_multi_edge_pulse_gen
// Two instances share all inputs: one built without retrigger and one
// built with it. A time-based reference model predicts every output on
// every cycle. Directed scenarios are followed by a randomized run.

module tb_multi_edge_pulse_gen;

   localparam int CH = 3;
   localparam int CW = 6;
   localparam int SS = 2;
   localparam int MW = 2 * CH;

   logic          clk = 1'b0;
   logic          reset;
   logic [CH-1:0] signal_in;
   logic [CH-1:0] enable;
   logic [MW-1:0] edge_mode;
   logic [CW-1:0] pulse_len;
   logic [CW-1:0] holdoff_len;
   logic [CH-1:0] clear;
   logic [CH-1:0] pulse_o  [2];
   logic [CH-1:0] busy_o   [2];
   logic [CH-1:0] sticky_o [2];

   always #5 clk = ~clk;

   multi_edge_pulse_gen #(
      .CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .RETRIGGER(0)
   ) u_dut0 (
      .clk(clk), .reset(reset), .signal_in(signal_in), .enable(enable),
      .edge_mode(edge_mode), .pulse_len(pulse_len), .holdoff_len(holdoff_len),
      .clear(clear), .pulse_out(pulse_o[0]), .busy(busy_o[0]),
      .event_sticky(sticky_o[0])
   );

   multi_edge_pulse_gen #(
      .CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .RETRIGGER(1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .signal_in(signal_in), .enable(enable),
      .edge_mode(edge_mode), .pulse_len(pulse_len), .holdoff_len(holdoff_len),
      .clear(clear), .pulse_out(pulse_o[1]), .busy(busy_o[1]),
      .event_sticky(sticky_o[1])
   );

   // Reference model state: edges are numbered from 1 after reset release.
   // A channel is described by the edge at which its pulse ends and the
   // edge at which its busy period ends.
   int            cyc;
   logic [CH-1:0] in_q [$];
   int            p_end [2][CH];
   int            h_end [2][CH];
   int            h_lat [2][CH];
   logic [CH-1:0] exp_pulse  [2];
   logic [CH-1:0] exp_busy   [2];
   logic [CH-1:0] exp_sticky [2];

   // Observed-pulse measurements used by the directed scenarios.
   int            hi_cnt   [2][CH];
   int            rise_cnt [2][CH];
   int            first_hi [2][CH];
   logic [CH-1:0] last_p   [2];

   int n_checks;
   int n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Input sampled at edge k (zero before the first edge after reset).
   function automatic logic [CH-1:0] get_in(input int k);
      if (k < 1 || k > in_q.size()) return '0;
      return in_q[k-1];
   endfunction

   task automatic model_reset();
      cyc = 0;
      in_q.delete();
      for (int d = 0; d < 2; d++) begin
         exp_pulse[d]  = '0;
         exp_busy[d]   = '0;
         exp_sticky[d] = '0;
         for (int ch = 0; ch < CH; ch++) begin
            p_end[d][ch] = 0;
            h_end[d][ch] = 0;
            h_lat[d][ch] = 0;
         end
      end
   endtask

   task automatic meas_reset();
      for (int d = 0; d < 2; d++)
         for (int ch = 0; ch < CH; ch++) begin
            hi_cnt[d][ch]   = 0;
            rise_cnt[d][ch] = 0;
            first_hi[d][ch] = -1;
         end
   endtask

   // Advance the model by one clock edge, using the inputs seen at that edge.
   task automatic model_edge();
      logic [CH-1:0] s_v;
      logic [CH-1:0] p_v;
      int            len;
      int            hold;
      bit            armed;
      in_q.push_back(signal_in);
      s_v   = get_in(cyc - SS);
      p_v   = get_in(cyc - SS - 1);
      len   = (pulse_len == '0) ? 1 : int'(pulse_len);
      hold  = int'(holdoff_len);
      armed = (cyc >= SS + 2);
      for (int ch = 0; ch < CH; ch++) begin
         bit rise;
         bit fall;
         bit qual;
         rise = s_v[ch] & ~p_v[ch];
         fall = ~s_v[ch] & p_v[ch];
         qual = armed && ((rise && edge_mode[2*ch]) || (fall && edge_mode[2*ch+1]));
         for (int d = 0; d < 2; d++) begin
            bit hit;
            hit = 1'b0;
            if (!enable[ch]) begin
               p_end[d][ch] = cyc;
               h_end[d][ch] = cyc;
            end else if (cyc > h_end[d][ch]) begin
               if (qual) begin
                  p_end[d][ch] = cyc + len;
                  h_lat[d][ch] = hold;
                  h_end[d][ch] = cyc + len + hold;
                  hit = 1'b1;
               end
            end else if (cyc <= p_end[d][ch] && d == 1 && qual) begin
               p_end[d][ch] = cyc + len;
               h_end[d][ch] = cyc + len + h_lat[d][ch];
               hit = 1'b1;
            end
            exp_pulse[d][ch] = (cyc < p_end[d][ch]);
            exp_busy[d][ch]  = (cyc < h_end[d][ch]);
            if (hit) exp_sticky[d][ch] = 1'b1;
            else if (clear[ch]) exp_sticky[d][ch] = 1'b0;
         end
      end
   endtask

   task automatic compare();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("pulse_out rt%0d cyc%0d", d, cyc), 32'(pulse_o[d]), 32'(exp_pulse[d]));
         check($sformatf("busy rt%0d cyc%0d", d, cyc), 32'(busy_o[d]), 32'(exp_busy[d]));
         check($sformatf("event_sticky rt%0d cyc%0d", d, cyc), 32'(sticky_o[d]), 32'(exp_sticky[d]));
         for (int ch = 0; ch < CH; ch++) begin
            if (pulse_o[d][ch] === 1'b1) begin
               hi_cnt[d][ch]++;
               if (first_hi[d][ch] < 0) first_hi[d][ch] = cyc;
               if (last_p[d][ch] !== 1'b1) rise_cnt[d][ch]++;
            end
         end
         last_p[d] = pulse_o[d];
      end
   endtask

   // One clock: model at the rising edge, compare 1 ns later, then return
   // on the falling edge so the caller drives inputs away from the edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      compare();
      @(negedge clk);
   endtask

   // Assert reset asynchronously, confirm outputs clear at once, release.
   task automatic apply_reset();
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("async rst pulse_out rt%0d", d), 32'(pulse_o[d]), 32'd0);
         check($sformatf("async rst busy rt%0d", d), 32'(busy_o[d]), 32'd0);
         check($sformatf("async rst sticky rt%0d", d), 32'(sticky_o[d]), 32'd0);
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int k;
      n_checks    = 0;
      n_pass      = 0;
      reset       = 1'b1;
      signal_in   = '0;
      enable      = '1;
      edge_mode   = '0;
      pulse_len   = '0;
      holdoff_len = '0;
      clear       = '0;
      last_p[0]   = '0;
      last_p[1]   = '0;
      model_reset();
      meas_reset();

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset pulse_out rt%0d", d), 32'(pulse_o[d]), 32'd0);
         check($sformatf("reset busy rt%0d", d), 32'(busy_o[d]), 32'd0);
         check($sformatf("reset sticky rt%0d", d), 32'(sticky_o[d]), 32'd0);
      end
      reset = 1'b0;
      repeat (6) tick();

      // Rising edge, pulse_len 6, no hold-off: 6-cycle pulse, latency 2
      edge_mode[1:0] = 2'b01;
      pulse_len      = CW'(6);
      holdoff_len    = CW'(0);
      meas_reset();
      signal_in[0] = 1'b1;
      k = cyc + 1;
      repeat (12) tick();
      check("rise width rt0", hi_cnt[0][0], 6);
      check("rise width rt1", hi_cnt[1][0], 6);
      check("rise latency", first_hi[0][0] - k, 2);
      check("rise sticky", 32'(sticky_o[0][0]), 32'd1);
      signal_in[0] = 1'b0;
      repeat (6) tick();

      // Both-edge mode with pulse_len 0: one 1-cycle pulse per toggle
      edge_mode[3:2] = 2'b11;
      pulse_len      = CW'(0);
      meas_reset();
      k = cyc + 1;
      for (int t = 0; t < 4; t++) begin
         signal_in[1] = ~signal_in[1];
         repeat (20) tick();
      end
      check("both-edge high cycles", hi_cnt[0][1], 4);
      check("both-edge pulse count", rise_cnt[0][1], 4);
      check("both-edge latency", first_hi[0][1] - k, 2);

      // Hold-off drops an edge inside the lockout, accepts one after it
      edge_mode[5:4] = 2'b11;
      pulse_len      = CW'(4);
      holdoff_len    = CW'(10);
      meas_reset();
      signal_in[2] = ~signal_in[2];
      repeat (6) tick();
      clear[2] = 1'b1;
      tick();
      clear[2] = 1'b0;
      tick();
      signal_in[2] = ~signal_in[2];
      repeat (16) tick();
      check("holdoff drop sticky rt0", 32'(sticky_o[0][2]), 32'd0);
      check("holdoff drop sticky rt1", 32'(sticky_o[1][2]), 32'd0);
      signal_in[2] = ~signal_in[2];
      repeat (20) tick();
      check("holdoff pulse count", rise_cnt[0][2], 2);
      check("holdoff high cycles", hi_cnt[0][2], 8);
      check("holdoff re-accept sticky", 32'(sticky_o[0][2]), 32'd1);

      // Second edge 3 cycles into a 5-cycle pulse
      pulse_len   = CW'(5);
      holdoff_len = CW'(0);
      meas_reset();
      signal_in[1] = ~signal_in[1];
      repeat (3) tick();
      signal_in[1] = ~signal_in[1];
      repeat (15) tick();
      check("no-retrigger width", hi_cnt[0][1], 5);
      check("retrigger width", hi_cnt[1][1], 8);
      check("retrigger pulse count", rise_cnt[1][1], 1);

      // Enable dropped on cycle 2 of a 10-cycle pulse
      edge_mode[1:0] = 2'b01;
      pulse_len      = CW'(10);
      holdoff_len    = CW'(5);
      meas_reset();
      signal_in[0] = 1'b1;
      repeat (4) tick();
      enable[0] = 1'b0;
      tick();
      check("abort pulse_out", 32'(pulse_o[0][0]), 32'd0);
      check("abort busy", 32'(busy_o[1][0]), 32'd0);
      enable[0] = 1'b1;
      repeat (20) tick();
      check("abort total width", hi_cnt[0][0], 2);

      // Clear coinciding with a newly accepted edge: set wins
      pulse_len   = CW'(2);
      holdoff_len = CW'(0);
      signal_in[2] = ~signal_in[2];
      repeat (2) tick();
      clear[2] = 1'b1;
      tick();
      clear[2] = 1'b0;
      check("clear vs set rt0", 32'(sticky_o[0][2]), 32'd1);
      check("clear vs set rt1", 32'(sticky_o[1][2]), 32'd1);
      repeat (6) tick();

      // Reset mid-pulse, with channel 0 held high through reset release
      pulse_len      = CW'(6);
      edge_mode[1:0] = 2'b11;
      signal_in[0]   = 1'b0;
      repeat (6) tick();
      signal_in[2] = ~signal_in[2];
      repeat (4) tick();
      check("mid-pulse before reset", 32'(pulse_o[0][2]), 32'd1);
      signal_in[0] = 1'b1;
      apply_reset();

      // No spurious edge from the held level; the later fall pulses
      pulse_len = CW'(3);
      meas_reset();
      repeat (10) tick();
      check("held-high no pulse rt0", hi_cnt[0][0], 0);
      check("held-high no pulse rt1", hi_cnt[1][0], 0);
      signal_in[0] = 1'b0;
      repeat (10) tick();
      check("fall after arm width", hi_cnt[0][0], 3);

      // Randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         for (int ch = 0; ch < CH; ch++) begin
            if ($urandom_range(0, 7) == 0) signal_in[ch] = ~signal_in[ch];
            enable[ch] = ($urandom_range(0, 39) != 0);
            clear[ch]  = ($urandom_range(0, 11) == 0);
         end
         if ($urandom_range(0, 49) == 0) edge_mode = MW'($urandom);
         if ($urandom_range(0, 29) == 0) pulse_len = CW'($urandom_range(0, 12));
         if ($urandom_range(0, 29) == 0) holdoff_len = CW'($urandom_range(0, 12));
         if (n == 1500) apply_reset();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
